// File: rtl/hazard_unit_if.sv
// hazard_unit_if
//   Decode/Execute-side signals exchanged between the core pipeline and the
//   hazard controller.
//   master : the pipeline; drives the Decode fields and PCSrcE, receives the
//            forwarding selects and stall/flush controls.
//   slave  : the hazard unit.
//   Signals: Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE (to hazard unit)
//            ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE (from it)
interface hazard_unit_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D;
    logic [REG_ADDR_WIDTH-1:0] Rs2D;
    logic [REG_ADDR_WIDTH-1:0] RdD;
    logic                      RegWriteD;
    logic [1:0]                ResultSrcD;
    logic                      PCSrcE;
    logic [1:0]                ForwardAE;
    logic [1:0]                ForwardBE;
    logic                      StallF;
    logic                      StallD;
    logic                      FlushD;
    logic                      FlushE;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard controller for the five-stage RV32I pipeline. Tracks a shadow copy
//   of the register addresses and write-back controls for E, M and W, and
//   from that plus the current Decode fields produces the Execute operand
//   forwarding selects and the Fetch/Decode/Execute stall/flush controls.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset; all outputs forced to 0 while high
//     hz   - hazard_unit_if.slave (Decode fields, PCSrcE in; selects,
//            stall/flush out)
//
//   Build option HAZARD_FORWARD_EN:
//     defined   - M/W forwarding plus a one-bubble load-use stall
//     undefined - no forwarding (selects stay 00); any dependency on an
//                 in-flight E or M writer stalls Decode instead
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

    // Shadow pipeline
    logic [REG_ADDR_WIDTH-1:0] r_rs1_e, r_rs2_e, r_rd_e;
    logic                      r_regwrite_e;
    logic [1:0]                r_resultsrc_e;
    logic [REG_ADDR_WIDTH-1:0] r_rd_m;
    logic                      r_regwrite_m;
    logic [REG_ADDR_WIDTH-1:0] r_rd_w;
    logic                      r_regwrite_w;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_hazard;   // data hazard needing a Decode stall + E bubble
    logic       w_stall;
    logic       w_flush_e;

    // A taken branch discards the Decode instruction, so it wins over any stall.
    assign w_stall   = w_hazard & ~hz.PCSrcE;
    assign w_flush_e = w_hazard | hz.PCSrcE;

`ifdef HAZARD_FORWARD_EN
    always_comb begin
        w_fwd_a = 2'b00;
        if (r_regwrite_m && (r_rd_m != X0) && (r_rd_m == r_rs1_e))
            w_fwd_a = 2'b10;
        else if (r_regwrite_w && (r_rd_w != X0) && (r_rd_w == r_rs1_e))
            w_fwd_a = 2'b01;
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (r_regwrite_m && (r_rd_m != X0) && (r_rd_m == r_rs2_e))
            w_fwd_b = 2'b10;
        else if (r_regwrite_w && (r_rd_w != X0) && (r_rd_w == r_rs2_e))
            w_fwd_b = 2'b01;
    end

    // Only a load in E is unresolvable by forwarding; one bubble moves it to
    // M, and from W its data reaches E through the 01 path.
    assign w_hazard = r_regwrite_e && (r_resultsrc_e == 2'b01) && (r_rd_e != X0) &&
                      ((r_rd_e == hz.Rs1D) || (r_rd_e == hz.Rs2D));
`else
    logic w_dep_rs1;
    logic w_dep_rs2;
    // Kept for a uniform shadow pipeline; without forwarding, W-stage
    // writers are covered by the register file's write-before-read.
    logic w_unused_nofwd;

    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;

    assign w_dep_rs1 = (hz.Rs1D != X0) &&
                       ((r_regwrite_e && (r_rd_e == hz.Rs1D)) ||
                        (r_regwrite_m && (r_rd_m == hz.Rs1D)));
    assign w_dep_rs2 = (hz.Rs2D != X0) &&
                       ((r_regwrite_e && (r_rd_e == hz.Rs2D)) ||
                        (r_regwrite_m && (r_rd_m == hz.Rs2D)));
    assign w_hazard  = w_dep_rs1 | w_dep_rs2;

    assign w_unused_nofwd = ^{r_resultsrc_e, r_rd_w, r_regwrite_w};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1_e       <= '0;
            r_rs2_e       <= '0;
            r_rd_e        <= '0;
            r_regwrite_e  <= 1'b0;
            r_resultsrc_e <= 2'b00;
            r_rd_m        <= '0;
            r_regwrite_m  <= 1'b0;
            r_rd_w        <= '0;
            r_regwrite_w  <= 1'b0;
        end else begin
            if (w_flush_e) begin
                r_rs1_e       <= '0;
                r_rs2_e       <= '0;
                r_rd_e        <= '0;
                r_regwrite_e  <= 1'b0;
                r_resultsrc_e <= 2'b00;
            end else begin
                r_rs1_e       <= hz.Rs1D;
                r_rs2_e       <= hz.Rs2D;
                r_rd_e        <= hz.RdD;
                r_regwrite_e  <= hz.RegWriteD;
                r_resultsrc_e <= hz.ResultSrcD;
            end
            r_rd_m       <= r_rd_e;
            r_regwrite_m <= r_regwrite_e;
            r_rd_w       <= r_rd_m;
            r_regwrite_w <= r_regwrite_m;
        end
    end

    // Outputs are quiet for the whole reset window.
    assign hz.ForwardAE = rst ? 2'b00 : w_fwd_a;
    assign hz.ForwardBE = rst ? 2'b00 : w_fwd_b;
    assign hz.StallF    = ~rst & w_stall;
    assign hz.StallD    = ~rst & w_stall;
    assign hz.FlushD    = ~rst & hz.PCSrcE;
    assign hz.FlushE    = ~rst & w_flush_e;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if #(.REG_ADDR_WIDTH(5)) hz ();

    hazard_unit #(.REG_ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Apply one Decode cycle just after the edge and queue its expected outputs.
    task automatic step(input string n, input bit r,
                        input int rs1, input int rs2, input int rd,
                        input bit rw, input bit [1:0] src, input bit pc,
                        input bit [1:0] fa, input bit [1:0] fb,
                        input bit sf, input bit sd, input bit fd, input bit fe);
        exp_t e;
        logic [4:0] a1, a2, ad;
        @(posedge clk);
        #1;
        a1 = rs1[4:0];
        a2 = rs2[4:0];
        ad = rd[4:0];
        rst           = r;
        hz.Rs1D       = a1;
        hz.Rs2D       = a2;
        hz.RdD        = ad;
        hz.RegWriteD  = rw;
        hz.ResultSrcD = src;
        hz.PCSrcE     = pc;
        e.name = n; e.fa = fa; e.fb = fb;
        e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic rst_rand(input string n);
        step(n, 1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (hz.ForwardAE !== e.fa || hz.ForwardBE !== e.fb ||
                    hz.StallF !== e.sf || hz.StallD !== e.sd ||
                    hz.FlushD !== e.fd || hz.FlushE !== e.fe) begin
                    fails++;
                    $display("FAIL %s: got FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b, want FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b",
                             e.name, hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
                             hz.FlushD, hz.FlushE, e.fa, e.fb, e.sf, e.sd, e.fd, e.fe);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0;
        hz.RegWriteD = 1'b0; hz.ResultSrcD = 2'b00; hz.PCSrcE = 1'b0;

        rst_rand("rst_hold0");
        rst_rand("rst_hold1");
        //    name        rst rs1 rs2 rd rw src pc   FA FB SF SD FD FE
        step("rel",        0,  3,  4, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
        step("alu_a",      0,  1,  2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("alu_s",      0,  5,  5, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("alu_fwd_m",  0,  0,  0, 0, 0, 0, 0,   2, 2, 0, 0, 0, 0);
        step("gap_a",      0,  1,  2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("gap_nop",    0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("gap_s",      0,  5,  5, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("gap_fwd_w",  0,  0,  0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        step("dh_a1",      0,  1,  2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("dh_a2",      0,  1,  2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("dh_r",       0,  5,  5, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("dh_m_prio",  0,  0,  0, 0, 0, 0, 0,   2, 2, 0, 0, 0, 0);
        step("x0_a1",      0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("x0_a2",      0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("x0_r",       0,  0,  0, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("x0_nofwd",   0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("ld",         0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("lu_stall",   0,  7,  1, 8, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("lu_go",      0,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("lu_fwd_w",   0,  0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step("bb_l1",      0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("bb_l2_st",   0,  7,  0, 8, 1, 1, 0,   0, 0, 1, 1, 0, 1);
        step("bb_l2_go",   0,  7,  0, 8, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("bb_u_st",    0,  8,  0, 9, 1, 0, 0,   1, 0, 1, 1, 0, 1);
        step("bb_u_go",    0,  8,  0, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("bb_fwd_w",   0,  0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step("br_ld",      0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("br_hit",     0,  7,  1, 8, 1, 0, 1,   0, 0, 0, 0, 1, 1);
        step("br_e_zero",  0,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("br_fwd_w",   0,  0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step("rs_ld",      0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("rs_stall",   0,  7,  1, 8, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("rs_hold",    1,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("rs_release", 0,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("pc_only",    0,  0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1);
        step("tail",       0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
`else
        step("alu_a",      0,  1,  2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("alu_st_e",   0,  5,  5, 6, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("alu_st_m",   0,  5,  5, 6, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("alu_go",     0,  5,  5, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("nop1",       0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("gap_a",      0,  1,  2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("gap_nop",    0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("gap_st_m",   0,  5,  5, 6, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("gap_go",     0,  5,  5, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("nop2",       0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("x0_w",       0,  1,  2, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("x0_r",       0,  0,  0, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("ld",         0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("lu_st_e",    0,  7,  1, 8, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("lu_st_m",    0,  7,  1, 8, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("lu_go",      0,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("br_ld",      0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("br_hit",     0,  7,  1, 8, 1, 0, 1,   0, 0, 0, 0, 1, 1);
        step("br_e_zero",  0,  8, 10, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("rs_ld",      0,  1,  0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step("rs_stall",   0,  7,  1, 8, 1, 0, 0,   0, 0, 1, 1, 0, 1);
        step("rs_hold",    1,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("rs_release", 0,  7,  1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("pc_only",    0,  0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1);
        step("tail",       0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
`endif

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline hazard controller for the five-stage RV32I core.
- Produces the forwarding selects `ForwardAE`/`ForwardBE` consumed by the Execute-stage operand muxes.
- Produces the stall/flush controls for the Fetch/Decode/Execute pipeline registers.
- Keeps its own shadow pipeline of register addresses and write-back control for E, M and W, so every decision comes from registered state plus the current Decode inputs.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, default 5: register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Rs1D` in REG_ADDR_WIDTH: Decode source 1.
- `Rs2D` in REG_ADDR_WIDTH: Decode source 2.
- `RdD` in REG_ADDR_WIDTH: Decode destination.
- `RegWriteD` in 1: Decode instruction writes `RdD`.
- `ResultSrcD` in 2: Decode result select; 00 ALU, 01 load data, 10 PC+4.
- `PCSrcE` in 1: branch/jump taken, resolved in Execute.
- `ForwardAE` out 2: SrcA select; 00 register file, 01 W result, 10 M ALU result.
- `ForwardBE` out 2: SrcB select; same encoding as `ForwardAE`.
- `StallF` out 1: hold PC.
- `StallD` out 1: hold the F/D register.
- `FlushD` out 1: clear the F/D register.
- `FlushE` out 1: clear the D/E register.

## Operation
Shadow registers:
- E stage holds Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE.
- M stage holds RdM, RegWriteM.
- W stage holds RdW, RegWriteW.
- Each rising edge: D→E loads the Decode inputs, E→M and M→W copy the stage before.
- If `FlushE` = 1 that cycle, E loads all zeros (bubble). M and W still advance.

Forwarding, evaluated per operand X ∈ {1,2}:
- If RegWriteM, RdM≠0 and RdM==RsXE → 10.
- Else if RegWriteW, RdW≠0 and RdW==RsXE → 01.
- Else → 00.
- M has priority over W. x0 is never forwarded.

Load-use stall:
- `lwStall` = RegWriteE & (ResultSrcE==01) & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- When set: `StallF` = `StallD` = 1 and `FlushE` = 1.
- Result is exactly one bubble; the next cycle the load is in M and its data is forwarded from W one cycle later, with no second stall.

Control hazard:
- `PCSrcE` → `FlushD` = 1, `FlushE` = 1.
- `PCSrcE` overrides the stall: when `PCSrcE` = 1, `StallF` = `StallD` = 0, because the instruction in D is discarded anyway.

Write-back to Decode, same cycle:
- Resolved by the register file's write-before-read.
- No stall and no forward from this block.

## Timing
- All outputs are combinational from the shadow registers and the current D inputs; zero-cycle latency within the cycle.
- Stall/flush take effect on the next rising edge.
- Reset: on a `rst` edge all shadow registers clear to 0. While `rst` is held, all outputs = 0.
- Reset mid-stall cancels the stall on the following cycle; the pipeline restarts with empty E/M/W.
- Back-to-back loads feeding each other give one bubble per dependent pair, never cumulative.

## Configuration
`HAZARD_FORWARD_EN`:
- Defined: forwarding and load-use stall behave as described above.
- Undefined: `ForwardAE` = `ForwardBE` = 00 constant. Instead, the block stalls (`StallF`, `StallD`, `FlushE`) whenever Rs1D or Rs2D (≠0) matches RdE with RegWriteE, or RdM with RegWriteM.
- Without forwarding, a dependent ALU pair costs two bubbles.
- `PCSrcE` priority is unchanged in both builds.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → all outputs 0. The first cycle after release with RegWriteD=0 → all outputs 0.
- ALU chain: `add x5` then `sub x6,x5,x5` → the cycle the `sub` is in E, `ForwardAE` = `ForwardBE` = 10. With a one-instruction gap → 01.
- Double hit: x5 written by the M and W instructions, read in E → 10 (M priority). Same sequence with destination x0 → 00.
- Load-use: `lw x7` then `add x8,x7,x1` → one cycle of `StallF` = `StallD` = `FlushE` = 1. The next cycle the stall is 0, and when `add` is in E, `ForwardAE` = 01.
- Branch: `PCSrcE` = 1 in the same cycle as a load-use match in D → `FlushD` = `FlushE` = 1, `StallF` = `StallD` = 0. The next cycle the E shadow is zero.
- `HAZARD_FORWARD_EN` undefined: the ALU chain from scenario 2 → exactly 2 stall cycles, `ForwardAE` = `ForwardBE` = 00 throughout.
